// File: rtl/logicgates_result_checker_if.sv
// Sample and failure-record bundle for the logic-gate result checker.
// The checker is the slave; the source/logger side is the master.
interface logicgates_result_checker_if;
    logic       in_valid;
    logic       a;
    logic       b;
    logic       y1;
    logic       y2;
    logic       y3;
    logic       y4;
    logic       y5;
    logic       y6;
    logic       rec_valid;
    logic [7:0] rec_data;
    logic       rec_ready;

    modport master (
        output in_valid, a, b, y1, y2, y3, y4, y5, y6, rec_ready,
        input  rec_valid, rec_data
    );

    modport slave (
        input  in_valid, a, b, y1, y2, y3, y4, y5, y6, rec_ready,
        output rec_valid, rec_data
    );
endinterface

// File: rtl/logicgates_result_checker.sv
// Scoreboard for the mux-based logic-gate block: compares y1..y6 against the
// golden gate functions of a/b, keeps statistics and queues failure records.
module logicgates_result_checker #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    logicgates_result_checker_if.slave    bus,
    output logic [CNT_W-1:0]              pass_cnt,
    output logic [CNT_W-1:0]              fail_cnt,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [5:0]                    err_vec,
    output logic                          err_any,
    output logic                          rec_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             flush;
    logic             s1_valid;
    logic             s1_a;
    logic             s1_b;
    logic [5:0]       s1_y;
    logic [5:0]       expected;
    logic [5:0]       mismatch;
    logic             pass_hit;
    logic             push_req;
    logic             push_en;
    logic             pop_en;
    logic             drop_en;
    logic             fifo_full;
    logic [7:0]       rec_in;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    // clr behaves exactly like rst, so both collapse into one flush term
    assign flush = rst | clr;

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_valid <= 1'b0;
            s1_a     <= 1'b0;
            s1_b     <= 1'b0;
            s1_y     <= 6'd0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a <= bus.a;
                s1_b <= bus.b;
                s1_y <= {bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1};
            end
        end
    end

    // Bit order follows the fixed mapping: AND, OR, NAND, NOR, XOR, XNOR
    always_comb begin
        expected    = 6'd0;
        expected[0] = s1_a & s1_b;
        expected[1] = s1_a | s1_b;
        expected[2] = ~(s1_a & s1_b);
        expected[3] = ~(s1_a | s1_b);
        expected[4] = s1_a ^ s1_b;
        expected[5] = ~(s1_a ^ s1_b);
    end

    assign mismatch  = s1_y ^ expected;
    assign pass_hit  = !flush && s1_valid && (mismatch == 6'd0);
    assign push_req  = !flush && s1_valid && (mismatch != 6'd0);
    assign rec_in    = {s1_a, s1_b, mismatch};

    assign fifo_full     = (occ == FULL_OCC);
    assign bus.rec_valid = (occ != '0);
    assign bus.rec_data  = bus.rec_valid ? mem[rd_ptr] : 8'h00;

    // A pop on a full FIFO frees the slot the incoming record lands in
    assign pop_en  = !flush && bus.rec_valid && bus.rec_ready;
    assign push_en = push_req && (!fifo_full || pop_en);
    assign drop_en = push_req && fifo_full && !pop_en;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= rec_in;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_en && !pop_en) begin
                occ <= occ + 1'b1;
            end else if (pop_en && !push_en) begin
                occ <= occ - 1'b1;
            end
        end
    end

    // Statistics saturate rather than wrap so a long run never reads as clean
    always_ff @(posedge clk) begin
        if (flush) begin
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            drop_cnt     <= '0;
            err_vec      <= 6'd0;
            rec_overflow <= 1'b0;
        end else begin
            if (pass_hit && (pass_cnt != CNT_MAX)) begin
                pass_cnt <= pass_cnt + 1'b1;
            end
            if (push_req) begin
                err_vec <= err_vec | mismatch;
                if (fail_cnt != CNT_MAX) begin
                    fail_cnt <= fail_cnt + 1'b1;
                end
            end
            if (drop_en) begin
                rec_overflow <= 1'b1;
                if (drop_cnt != CNT_MAX) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    assign err_any = |err_vec;

endmodule
